html_rom_char_stream: RTL and testbench
=======================================

Name: html_rom_char_stream

Overview:
- Synthesizable upstream character source for the parsers, replacing the hard-coded test stream.
- Fetches an HTML byte string from a synchronous ROM/RAM read port starting at a loadable base address.
- Hands characters one at a time to a downstream parser (e.g. integer_parser) using the level request handshake: the consumer drives its next_char output into state_enable.
- Flags end of stream on a NUL byte or when a programmed length is exhausted.

Parameters:
CHAR_W, 8, character width; matches `CHAR_BITES.
ADDR_W, 10, memory address width.
LEN_W, 11, width of length and counter fields; must be ≥ ADDR_W+1.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse: load base_addr/length, begin a new stream.
base_addr  input  ADDR_W  first byte address; sampled on start.
length  input  LEN_W  max bytes to read; 0 = stream is immediately finished; sampled on start.
state_enable  input  1  consumer request level; one char delivered per high episode.
mem_rd  output  1  memory read strobe, one cycle.
mem_addr  output  ADDR_W  memory read address, registered.
mem_data  input  CHAR_W  read data, valid in the cycle after mem_rd is high.
char  output  CHAR_W  current character, held until replaced.
char_valid  output  1  one-cycle pulse when char updates.
has_finished  output  1  sticky end-of-stream flag.
char_count  output  LEN_W  number of characters delivered since start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; char=0, char_valid=0, has_finished=0, mem_rd=0, mem_addr=0, char_count=0; internal pointer and remaining count cleared.
- Reset mid-fetch: any in-flight read is discarded; no char_valid is issued after release.

States:
- IDLE: wait for start. On start: ptr←base_addr, remaining←length, char_count←0, has_finished←0.
  - If length=0: has_finished←1 next edge, go to DONE.
  - Otherwise go to READY.
- READY: if state_enable=1 at edge N: mem_rd←1, mem_addr←ptr, go to FETCH.
- FETCH: mem_rd←0; go to CAPTURE.
- CAPTURE (edge N+2, mem_data valid):
  - If mem_data=0: has_finished←1, char unchanged, no char_valid, go to DONE.
  - Else: char←mem_data, char_valid←1 (one cycle), char_count+1, ptr+1, remaining−1, go to HOLD.
- HOLD: wait for state_enable=0, then go to READY. This prevents a long-held request from consuming multiple chars.
  - If remaining=0 on leaving HOLD: has_finished←1, go to DONE. No further reads.
- DONE: has_finished stays 1, char holds its last value, state_enable is ignored. A start pulse re-initialises as in IDLE.

Rules and corner cases:
- Latency: request sampled at edge N → char/char_valid at edge N+2. Maximum throughput is one char per 4 cycles (READY, FETCH, CAPTURE, HOLD with an enable drop).
- start is ignored in READY, FETCH, CAPTURE and HOLD; there is no abort except reset.
- ptr wraps modulo 2^ADDR_W; a wrap is not an error.
- char_count saturates at 2^LEN_W−1.
- state_enable high in the same cycle as start: the start load takes priority; the request is sampled from READY on the next edge.
- mem_rd is never high in two consecutive cycles.

Test Plan:
- ROM "1234567\0" at 0x010, base=0x010, length=20, consumer holds state_enable high then low per char → seven char_valid pulses carrying '1'..'7'; has_finished=1 after the NUL read; char stays '7'; char_count=7.
- Same ROM, length=3 → chars '1','2','3'; has_finished=1 after HOLD exits; exactly 3 mem_rd pulses.
- start with length=0 → has_finished=1 one cycle later; mem_rd never asserted.
- state_enable held high for 20 cycles → exactly one mem_rd and one char_valid; next char only after enable drops and rises again.
- reset driven low in the FETCH cycle → all outputs 0 immediately; no char_valid after release; a new start at base=0x3FE with data "AB" at 0x3FE/0x3FF and NUL at 0x000 → 'A','B', mem_addr wraps to 0x000, then has_finished=1.
- Integration with integer_parser fed "345\0" → parser value=345 and has_finished=1 from both blocks.

Source files
------------

// File: rtl/html_rom_char_stream.sv
// Character source: reads an HTML byte string from a synchronous memory port and
// hands it to a downstream parser one character per request episode.
module html_rom_char_stream #(
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              state_enable,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CHAR_W-1:0] mem_data,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic              has_finished,
  output logic [LEN_W-1:0]  char_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    FETCH   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  COUNT_MAX = {LEN_W{1'b1}};
  localparam logic [CHAR_W-1:0] CHAR_NUL  = {CHAR_W{1'b0}};

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [LEN_W-1:0]  remaining_r;

  // Stream FSM: the read strobe and char_valid default low so each is a single-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      ptr_r        <= {ADDR_W{1'b0}};
      remaining_r  <= LEN_ZERO;
      mem_rd       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      char         <= CHAR_NUL;
      char_valid   <= 1'b0;
      has_finished <= 1'b0;
      char_count   <= LEN_ZERO;
    end else begin
      mem_rd     <= 1'b0;
      char_valid <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            ptr_r       <= base_addr;
            remaining_r <= length;
            char_count  <= LEN_ZERO;
            if (length == LEN_ZERO) begin
              has_finished <= 1'b1;
              state_r      <= DONE;
            end else begin
              has_finished <= 1'b0;
              state_r      <= READY;
            end
          end
        end
        READY: begin
          if (state_enable) begin
            mem_rd   <= 1'b1;
            mem_addr <= ptr_r;
            state_r  <= FETCH;
          end
        end
        FETCH: begin
          state_r <= CAPTURE;
        end
        // mem_data now reflects the address strobed two edges ago.
        CAPTURE: begin
          if (mem_data == CHAR_NUL) begin
            has_finished <= 1'b1;
            state_r      <= DONE;
          end else begin
            char        <= mem_data;
            char_valid  <= 1'b1;
            ptr_r       <= ptr_r + ADDR_ONE;
            remaining_r <= remaining_r - LEN_ONE;
            if (char_count != COUNT_MAX) begin
              char_count <= char_count + LEN_ONE;
            end
            state_r <= HOLD;
          end
        end
        // A request held high across delivery must drop before the next fetch.
        HOLD: begin
          if (!state_enable) begin
            if (remaining_r == LEN_ZERO) begin
              has_finished <= 1'b1;
              state_r      <= DONE;
            end else begin
              state_r <= READY;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_html_rom_char_stream.sv
// Self-checking bench for html_rom_char_stream: a memory model, a pulse monitor and a
// reference model that derives each expected stream directly from memory contents.
module tb_html_rom_char_stream;
  localparam int CW = 8;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          state_enable = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data = '0;
  logic [CW-1:0] char;
  logic          char_valid;
  logic          has_finished;
  logic [LW-1:0] char_count;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] rom [0:1023];
  logic [7:0] got_q[$];
  int rd_cnt = 0;
  int valid_cnt = 0;
  int rd_b2b = 0;
  logic prev_rd = 1'b0;
  logic [7:0] exp_char = 8'h00;

  html_rom_char_stream #(.CHAR_W(CW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .state_enable(state_enable), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .char(char),
    .char_valid(char_valid), .has_finished(has_finished), .char_count(char_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_data <= rom[mem_addr];
  end

  always @(negedge clock) begin
    if (char_valid) begin
      got_q.push_back(char);
      valid_cnt++;
    end
    if (mem_rd) begin
      rd_cnt++;
      if (prev_rd) rd_b2b++;
    end
    prev_rd = mem_rd;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_str(input logic [AW-1:0] at, input string s);
    logic [AW-1:0] a;
    a = at;
    for (int i = 0; i < s.len(); i++) begin
      rom[a] = s[i];
      a = a + 10'd1;
    end
    rom[a] = 8'h00;
  endtask

  // Runs one complete stream as a well-behaved consumer and checks it against the model.
  task automatic run_stream(input logic [AW-1:0] b, input logic [LW-1:0] len,
                            input int hold, input bit en_with_start, input string name);
    logic [7:0] exp_q[$];
    logic [AW-1:0] a;
    bit nul;
    int guard, w, v0, mism;
    a = b;
    nul = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (rom[a] == 8'h00) begin
        nul = 1'b1;
        break;
      end
      exp_q.push_back(rom[a]);
      a = a + 10'd1;
    end
    got_q.delete();
    rd_cnt = 0;
    rd_b2b = 0;
    start = 1'b1; base_addr = b; length = len; state_enable = en_with_start;
    tick();
    start = 1'b0;
    check({name, "_start_fin"}, has_finished, (len == 0) ? 1 : 0);
    check({name, "_start_cnt"}, char_count, 0);
    guard = 0;
    while (!has_finished && guard < 40) begin
      state_enable = 1'b1;
      v0 = valid_cnt;
      w = 0;
      while (valid_cnt == v0 && !has_finished && w < 10) begin
        tick();
        w++;
      end
      repeat (hold) tick();
      state_enable = 1'b0;
      tick();
      tick();
      guard++;
    end
    if (guard >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: has_finished %0b, expected 1", name, has_finished);
    end
    repeat (3) tick();
    if (exp_q.size() > 0) exp_char = exp_q[exp_q.size()-1];
    check({name, "_nchars"}, got_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({name, "_chars"}, mism, 0);
    check({name, "_count"}, char_count, exp_q.size());
    check({name, "_fin"}, has_finished, 1);
    check({name, "_char"}, char, exp_char);
    check({name, "_reads"}, rd_cnt, exp_q.size() + (nul ? 1 : 0));
    check({name, "_rd_b2b"}, rd_b2b, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    check("rst_char", char, 0);
    check("rst_valid", char_valid, 0);
    check("rst_fin", has_finished, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_count", char_count, 0);
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_nul_terminated();
    load_str(10'h010, "1234567");
    run_stream(10'h010, 11'd20, 1, 1'b0, "nul");
  endtask

  task automatic test_length_limit();
    run_stream(10'h010, 11'd3, 0, 1'b0, "len3");
  endtask

  task automatic test_zero_length();
    run_stream(10'h010, 11'd0, 0, 1'b0, "len0");
    state_enable = 1'b1;
    repeat (10) tick();
    state_enable = 1'b0;
    check("len0_no_rd", rd_cnt, 0);
    check("len0_char_kept", char, exp_char);
  endtask

  task automatic test_long_request();
    int w;
    got_q.delete();
    rd_cnt = 0;
    start = 1'b1; base_addr = 10'h010; length = 11'd20;
    tick();
    start = 1'b0;
    state_enable = 1'b1;
    repeat (20) tick();
    check("long_reads", rd_cnt, 1);
    check("long_valids", got_q.size(), 1);
    check("long_char0", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h31);
    start = 1'b1; base_addr = 10'h200; length = 11'd0;
    tick();
    start = 1'b0;
    check("busy_start_ignored", has_finished, 0);
    state_enable = 1'b0;
    tick();
    tick();
    state_enable = 1'b1;
    w = 0;
    while (got_q.size() < 2 && w < 10) begin
      tick();
      w++;
    end
    check("long_char1", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h32);
    state_enable = 1'b0;
    tick();
    tick();
    exp_char = 8'h32;
  endtask

  task automatic test_reset_mid_fetch();
    int w, v0;
    state_enable = 1'b1;
    w = 0;
    while (!mem_rd && w < 10) begin
      tick();
      w++;
    end
    check("mid_fetch_reached", mem_rd, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_zero", {char, char_valid, has_finished, mem_rd, mem_addr, char_count}, 0);
    state_enable = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    exp_char = 8'h00;
    v0 = valid_cnt;
    repeat (6) tick();
    check("mid_rst_no_valid", valid_cnt, v0);
    load_str(10'h3FE, "AB");
    run_stream(10'h3FE, 11'd20, 1, 1'b0, "wrap");
    check("wrap_addr", mem_addr, 10'h000);
  endtask

  task automatic test_integration();
    int value;
    load_str(10'h100, "345");
    run_stream(10'h100, 11'd20, 0, 1'b1, "int");
    value = 0;
    foreach (got_q[i]) value = value * 10 + (int'(got_q[i]) - 48);
    check("int_value", value, 345);
  endtask

  task automatic test_random();
    logic [AW-1:0] b, a;
    logic [LW-1:0] len;
    for (int it = 0; it < 10; it++) begin
      b = AW'($urandom_range(0, 1023));
      len = LW'($urandom_range(0, 12));
      a = b;
      for (int i = 0; i < 16; i++) begin
        rom[a] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        a = a + 10'd1;
      end
      run_stream(b, len, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    test_reset();
    test_nul_terminated();
    test_length_limit();
    test_zero_length();
    test_long_request();
    test_reset_mid_fetch();
    test_integration();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
